// File: rtl/elc3_soc_nios2_qsys_0_ocimem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : elc3_soc_nios2_qsys_0_ocimem_ctrl
// Purpose  : Nios II OCI debug monitor memory controller. Owns a single-port
//            2^ADDR_W x 32 debug RAM and arbitrates it between JTAG debug
//            commands (take_action_* / jdo) and a CPU Avalon-MM slave.
//            JTAG requests always have priority over CPU requests.
// Ports    : clk, reset_n                 - clock, async active-low reset
//            jdo, take_action_ocimem_a/b,
//            take_no_action_ocimem_a      - JTAG command pulses and data
//            av_address/read/write/
//            writedata/byteenable         - CPU Avalon-MM request
//            av_readdata, av_waitrequest  - CPU Avalon-MM response
//            MonDReg, monitor_ready,
//            monitor_error                - JTAG shift-out status/data
// Config   : ELC3_OCIMEM_LOCK_EN - when defined, CPU writes below LOCK_TOP
//            are dropped and flag monitor_error.
// Revision : 1.0 - initial release
// ============================================================================
module elc3_soc_nios2_qsys_0_ocimem_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int LOCK_TOP = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  input  logic [3:0]        av_byteenable,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int          C_DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] C_LOCK_TOP = LOCK_TOP;
`ifdef ELC3_OCIMEM_LOCK_EN
  localparam bit          C_LOCK_EN  = 1'b1;
`else
  localparam bit          C_LOCK_EN  = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_JRD  = 3'd1,
    S_JWR  = 3'd2,
    S_CRD  = 3'd3,
    S_CWR  = 3'd4
  } state_t;

  // JTAG command kinds held in the pending slot
  typedef enum logic [1:0] {
    OP_RD_NOINC = 2'd0,   // take_action_ocimem_a with read
    OP_RD_INC   = 2'd1,   // take_no_action_ocimem_a
    OP_WR       = 2'd2    // take_action_ocimem_b
  } op_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t            state_q;
  logic [ADDR_W-1:0] mon_a_q;        // MonAReg
  logic [31:0]       mon_d_q;        // MonDReg
  logic              ready_q;
  logic              error_q;
  logic              waitreq_q;
  logic              pend_valid_q;
  op_t               pend_op_q;
  logic [31:0]       pend_data_q;
  logic              nop_q;          // address-only load completes next cycle
  logic [31:0]       rdata_q;
  logic [31:0]       mem_q [C_DEPTH];

  // --------------------------------------------------------------------------
  // JTAG command decode
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_jdo_addr;
  logic              w_jdo_rd;
  logic [31:0]       w_jdo_data;
  logic              w_any_pulse;
  logic              w_live_valid;
  op_t               w_live_op;
  logic              w_in_idle;
  logic              w_cmd_valid;
  op_t               w_cmd_op;
  logic              w_lock_hit;
  logic              w_unused_jdo;

  assign w_jdo_addr  = jdo[17 +: ADDR_W];
  assign w_jdo_rd    = jdo[34];
  assign w_jdo_data  = jdo[34:3];
  assign w_any_pulse = take_action_ocimem_a | take_action_ocimem_b |
                       take_no_action_ocimem_a;

  // Only commands that need a RAM cycle go through the FSM; an address-only
  // load is finished by the nop_q path.
  assign w_live_valid = (take_action_ocimem_a & w_jdo_rd) |
                        take_action_ocimem_b | take_no_action_ocimem_a;

  always_comb begin
    w_live_op = OP_RD_NOINC;
    if (take_action_ocimem_b) begin
      w_live_op = OP_WR;
    end else if (take_no_action_ocimem_a) begin
      w_live_op = OP_RD_INC;
    end
  end

  assign w_in_idle   = (state_q == S_IDLE);
  // A queued command is older than a live pulse, so it is served first.
  assign w_cmd_valid = pend_valid_q | w_live_valid;
  assign w_cmd_op    = pend_valid_q ? pend_op_q : w_live_op;

  assign w_lock_hit  = C_LOCK_EN && (32'(av_address) < C_LOCK_TOP);

  assign w_unused_jdo = &{1'b0, jdo[37:35], jdo[2:0]};

  // --------------------------------------------------------------------------
  // RAM port mux
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_ram_we;
  logic [3:0]        w_ram_be;
  logic [31:0]       w_ram_wdata;

  always_comb begin
    w_ram_addr  = av_address;
    w_ram_we    = 1'b0;
    w_ram_be    = 4'hF;
    w_ram_wdata = pend_data_q;
    case (state_q)
      S_IDLE: begin
        // The read address is issued in IDLE so JRD/CRD see data next cycle.
        // A live take_action_ocimem_a reads from the address it is loading,
        // since MonAReg only takes that value at the end of this cycle.
        if (pend_valid_q) begin
          w_ram_addr = mon_a_q;
        end else if (take_action_ocimem_a && w_jdo_rd) begin
          w_ram_addr = w_jdo_addr;
        end else if (w_live_valid) begin
          w_ram_addr = mon_a_q;
        end
      end
      S_JWR: begin
        w_ram_addr  = mon_a_q;
        w_ram_we    = 1'b1;
        w_ram_be    = 4'hF;
        w_ram_wdata = pend_data_q;
      end
      S_CWR: begin
        w_ram_addr  = av_address;
        w_ram_we    = ~w_lock_hit;
        w_ram_be    = av_byteenable;
        w_ram_wdata = av_writedata;
      end
      default: begin
      end
    endcase
  end

  // Debug RAM: synchronous read, byte-lane write, contents not reset.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_ram_be[b]) begin
          mem_q[w_ram_addr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
        end
      end
    end
    rdata_q <= mem_q[w_ram_addr];
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mon_a_q      <= '0;
      mon_d_q      <= '0;
      ready_q      <= 1'b1;
      error_q      <= 1'b0;
      waitreq_q    <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_op_q    <= OP_RD_NOINC;
      pend_data_q  <= '0;
      nop_q        <= 1'b0;
    end else begin
      if (w_in_idle && pend_valid_q) begin
        pend_valid_q <= 1'b0;
      end

      if (nop_q) begin
        nop_q   <= 1'b0;
        ready_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (w_cmd_valid) begin
            state_q   <= (w_cmd_op == OP_WR) ? S_JWR : S_JRD;
            waitreq_q <= 1'b1;
          end else if (av_read) begin
            state_q   <= S_CRD;
            waitreq_q <= 1'b0;
          end else if (av_write) begin
            state_q   <= S_CWR;
            waitreq_q <= 1'b0;
          end else begin
            waitreq_q <= 1'b1;
          end
        end
        S_JRD: begin
          mon_d_q <= rdata_q;
          ready_q <= 1'b1;
          if (pend_op_q == OP_RD_INC) begin
            mon_a_q <= mon_a_q + ADDR_W'(1);
          end
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
        S_JWR: begin
          mon_a_q   <= mon_a_q + ADDR_W'(1);
          ready_q   <= 1'b1;
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
        S_CRD: begin
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
        S_CWR: begin
          if (w_lock_hit) begin
            error_q <= 1'b1;
          end
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
        default: begin
          state_q   <= S_IDLE;
          waitreq_q <= 1'b1;
        end
      endcase

      // JTAG pulses are evaluated last so a fresh command always wins over
      // completion updates made in the same cycle.
      if (w_any_pulse) begin
        ready_q <= 1'b0;
      end

      if (take_action_ocimem_a) begin
        mon_a_q <= w_jdo_addr;
        error_q <= 1'b0;
        if (!w_jdo_rd) begin
          nop_q <= 1'b1;
        end
      end

      if (w_live_valid) begin
        // Op/data are recorded even when the FSM consumes the pulse straight
        // from IDLE: JRD and JWR read them back from the slot.
        pend_op_q <= w_live_op;
        if (take_action_ocimem_b) begin
          pend_data_q <= w_jdo_data;
        end
        if (!(w_in_idle && !pend_valid_q)) begin
          pend_valid_q <= 1'b1;
        end
      end
    end
  end

  assign av_readdata    = (state_q == S_CRD) ? rdata_q : 32'h0;
  assign av_waitrequest = waitreq_q;
  assign MonDReg        = mon_d_q;
  assign monitor_ready  = ready_q;
  assign monitor_error  = error_q;

endmodule
`default_nettype wire
